// File: rtl/and4_rr_scheduler_if.sv
// Requester/consumer bundle for and4_rr_scheduler.
// master = requesters plus response consumer, slave = the scheduler.
interface and4_rr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_ready;
  logic                  busy;

  // Handshakes:
  // - req[i] is held with its operands until gnt[i] is seen.
  //   Operands are captured on the edge that ends the gnt cycle.
  // - A response transfers on a rising edge where rsp_valid && rsp_ready.
  //   rsp_valid, rsp_id and rsp_result stay stable until that transfer.
  //   rsp_valid never waits on rsp_ready.
  modport master (
    output req, req_a, req_b, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req, req_a, req_b, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/and4_rr_scheduler.sv
// Round-robin scheduler that shares one 4-bit AND datapath (top_name)
// between NREQ requesters; one operation in flight, IDLE->EXEC->RESP.

module ander (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

module top_name (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);
  for (genvar g = 0; g < 4; g++) begin : g_slice
    ander u_ander (
      .a_i (a_i[g]),
      .b_i (b_i[g]),
      .y_o (y_o[g])
    );
  end
endmodule

module and4_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  and4_rr_scheduler_if.slave  bus,
  output logic [1:0]          dbg_state_o
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   win_oh;
  logic [IDW-1:0]    win_id;
  logic [WIDTH-1:0]  win_a, win_b;
  logic              found;
  logic [WIDTH-1:0]  and_y;
  logic [NREQ-1:0]   gnt_c;
  logic              rsp_valid_c;

  // Rotate req so bit 0 is the requester just after last; the first set
  // bit of the rotated vector is then the round-robin winner.
  always_comb begin
    req_dbl = {bus.req, bus.req} >> (int'(last_q) + 1);
    req_rot = req_dbl[NREQ-1:0];
    found   = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        win_id = IDW'((int'(last_q) + 1 + k) % NREQ);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    win_a  = '0;
    win_b  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_id == IDW'(j)) begin
        win_oh[j] = found;
        win_a     = bus.req_a[j*WIDTH +: WIDTH];
        win_b     = bus.req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  top_name u_top_name (
    .a_i (a_q),
    .b_i (b_q),
    .y_o (and_y)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    gnt_c       = '0;
    rsp_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_c   = win_oh;
          a_d     = win_a;
          b_d     = win_b;
          id_d    = win_id;
          last_d  = win_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = and_y;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= LAST_RST;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // rsp_valid decodes state_q so an asynchronous reset drops it at once.
  assign bus.gnt        = gnt_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.busy       = (state_q != IDLE);
  assign dbg_state_o    = state_q;
endmodule
